// File: rtl/mx_n_reg_arb.sv
// mx_n_reg_arb: N-channel registered mux, fixed-select or round-robin grant, valid/ready on both sides.
// Optional build macro MX_ZERO_IDLE_EN: out_data/out_ch read 0 whenever out_valid is low.
module mx_n_reg_arb #(
   parameter int unsigned N     = 7,
   parameter int unsigned W     = 32,
   parameter int unsigned SEL_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N*W-1:0]     in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   output logic [W-1:0]       out_data,
   output logic [SEL_W-1:0]   out_ch,
   output logic               out_valid,
   input  logic               out_ready
);

   logic [W-1:0]     out_data_q, out_data_d;
   logic [SEL_W-1:0] out_ch_q, out_ch_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] rr_last_q, rr_last_d;

   logic             grant_valid;
   logic [SEL_W-1:0] grant_ch;
   logic [W-1:0]     grant_data;
   logic             free;
   logic             xfer;
   int unsigned      rr_idx;

   // Grant: in-range valid sel in fixed mode, else first valid channel after rr_last
   always_comb begin
      grant_valid = 1'b0;
      grant_ch    = '0;
      rr_idx      = 0;
      if (!mode) begin
         for (int unsigned i = 0; i < N; i++) begin
            if ((SEL_W'(i) == sel) && in_valid[i]) begin
               grant_valid = 1'b1;
               grant_ch    = SEL_W'(i);
            end
         end
      end else begin
         // Walk farthest-first so the nearest requester after rr_last wins
         for (int unsigned k = N; k >= 1; k--) begin
            rr_idx = (32'(rr_last_q) + k) % N;
            for (int unsigned i = 0; i < N; i++) begin
               if ((i == rr_idx) && in_valid[i]) begin
                  grant_valid = 1'b1;
                  grant_ch    = SEL_W'(i);
               end
            end
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (SEL_W'(i) == grant_ch) begin
            grant_data = in_data[i*W +: W];
         end
      end
   end

   assign free = !out_valid_q || out_ready;
   assign xfer = reset_n && free && grant_valid;

   always_comb begin
      in_ready = '0;
      for (int unsigned i = 0; i < N; i++) begin
         in_ready[i] = xfer && (grant_ch == SEL_W'(i));
      end
   end

   // Output slot next state: load on transfer, drain when consumed with nothing new
   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      rr_last_d   = rr_last_q;
      if (xfer) begin
         out_data_d  = grant_data;
         out_ch_d    = grant_ch;
         out_valid_d = 1'b1;
         if (mode) begin
            rr_last_d = grant_ch;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
`ifdef MX_ZERO_IDLE_EN
         out_data_d  = '0;
         out_ch_d    = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         rr_last_q   <= SEL_W'(N - 1);
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         rr_last_q   <= rr_last_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mx_n_reg_arb.sv
// tb_mx_n_reg_arb: directed + random stimulus against a behavioural model of the registered mux/arbiter.
module tb_mx_n_reg_arb;

   localparam int unsigned N     = 7;
   localparam int unsigned W     = 32;
   localparam int unsigned SEL_W = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     in_valid;
   logic [N-1:0]     in_ready;
   logic             mode;
   logic [SEL_W-1:0] sel;
   logic [W-1:0]     out_data;
   logic [SEL_W-1:0] out_ch;
   logic             out_valid;
   logic             out_ready;

   int errors = 0;
   int checks = 0;

   mx_n_reg_arb #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: output slot contents and round-robin pointer
   logic         m_v;
   logic [W-1:0] m_d;
   int           m_ch;
   int           m_rr;

   function automatic int exp_grant();
      logic [15:0] v16;
      v16 = 16'(in_valid);
      if (!mode) begin
         if (int'(sel) < N && v16[sel]) return int'(sel);
         return -1;
      end
      for (int d = 1; d <= N; d++) begin
         int c;
         c = (m_rr + d) % N;
         if (v16[c]) return c;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_v = 1'b0; m_d = '0; m_ch = 0; m_rr = N - 1;
      end else begin
         int g;
         g = exp_grant();
         if ((!m_v || out_ready) && g >= 0) begin
            m_v  = 1'b1;
            m_d  = in_data[g*W +: W];
            m_ch = g;
            if (mode) m_rr = g;
         end else if (out_ready) begin
            m_v = 1'b0;
`ifdef MX_ZERO_IDLE_EN
            m_d = '0; m_ch = 0;
`endif
         end
      end
   end

   // Per-cycle compare against the model, mid-cycle when inputs are settled
   always @(negedge clk) begin
      logic [N-1:0] e_rdy;
      int g;
      g = exp_grant();
      e_rdy = '0;
      if (reset_n && (!m_v || out_ready) && g >= 0) e_rdy[g] = 1'b1;
      chk("cyc_in_ready", 64'(in_ready), 64'(e_rdy));
      chk("cyc_out_valid", 64'(out_valid), 64'(m_v));
      chk("cyc_out_data", 64'(out_data), 64'(m_d));
      chk("cyc_out_ch", 64'(out_ch), 64'(m_ch));
`ifdef MX_ZERO_IDLE_EN
      if (!out_valid) begin
         chk("idle_zero_data", 64'(out_data), 64'd0);
         chk("idle_zero_ch", 64'(out_ch), 64'd0);
      end
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ramp();
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i);
   endtask

   initial begin
      int exp_seq[9];
      reset_n   = 1'b0;
      in_data   = '0;
      in_valid  = '0;
      mode      = 1'b0;
      sel       = '0;
      out_ready = 1'b0;
      repeat (2) tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      reset_n = 1'b1;
      tick();

      // Fixed mode, sel=2
      mode = 1'b0; sel = 4'd2; in_valid = 7'b0000100; out_ready = 1'b1;
      in_data[2*W +: W] = 32'hDEAD_BEEF;
      #1 chk("fix_in_ready", 64'(in_ready), 64'(7'b0000100));
      tick();
      chk("fix_out_valid", 64'(out_valid), 64'd1);
      chk("fix_out_data", 64'(out_data), 64'hDEAD_BEEF);
      chk("fix_out_ch", 64'(out_ch), 64'd2);
      in_valid = '0;
      tick();

      // Out-of-range sel never grants
      sel = 4'd9; in_valid = '1;
      for (int i = 0; i < 10; i++) begin
         #1 chk("oor_in_ready", 64'(in_ready), 64'd0);
         tick();
         chk("oor_out_valid", 64'(out_valid), 64'd0);
      end

      // Round-robin over all channels, starting at 0 (pointer untouched by fixed grants)
      mode = 1'b1; in_valid = '1; set_ramp();
      exp_seq = '{0, 1, 2, 3, 4, 5, 6, 0, 1};
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("rr_seq_ch", 64'(out_ch), 64'(exp_seq[i]));
         chk("rr_seq_data", 64'(out_data), 64'(exp_seq[i]));
      end

      // Wrap between channels 6 and 0 (pointer now at 1)
      in_valid = 7'b1000001;
      tick(); chk("wrap_a", 64'(out_ch), 64'd6);
      tick(); chk("wrap_b", 64'(out_ch), 64'd0);
      tick(); chk("wrap_c", 64'(out_ch), 64'd6);
      in_valid = '0;
      tick();

      // Stall with changing data and sel
      mode = 1'b0; sel = 4'd3; in_valid = 7'b0001000;
      in_data[3*W +: W] = 32'h3333_3333;
      tick();
      out_ready = 1'b0; in_valid = '1;
      for (int i = 0; i < 5; i++) begin
         in_data = {N{$urandom()}};
         sel = SEL_W'($urandom_range(0, N - 1));
         mode = 1'($urandom());
         #1 chk("stall_in_ready", 64'(in_ready), 64'd0);
         tick();
         chk("stall_data", 64'(out_data), 64'h3333_3333);
         chk("stall_ch", 64'(out_ch), 64'd3);
         chk("stall_valid", 64'(out_valid), 64'd1);
      end
      mode = 1'b0; sel = 4'd5; out_ready = 1'b1;
      in_data[5*W +: W] = 32'h5555_AAAA;
      #1 chk("unstall_in_ready", 64'(in_ready), 64'(7'b0100000));
      tick();
      chk("unstall_ch", 64'(out_ch), 64'd5);
      chk("unstall_data", 64'(out_data), 64'h5555_AAAA);

      // Asynchronous reset mid-stream
      mode = 1'b1; in_valid = '1; set_ramp();
      tick(); tick();
      #2 reset_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_out_data", 64'(out_data), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd0);
      tick();
      reset_n = 1'b1; in_valid = 7'b0010100;
      #1 chk("arst_rr_ready", 64'(in_ready), 64'(7'b0000100));
      tick();
      chk("arst_rr_ch", 64'(out_ch), 64'd2);

      // Random phase, checked cycle-by-cycle against the model
      for (int i = 0; i < 400; i++) begin
         in_data   = {N{$urandom()}};
         in_valid  = N'($urandom());
         mode      = ($urandom_range(0, 7) != 0) ? mode : ~mode;
         sel       = SEL_W'($urandom());
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) == 0) begin
            #2 reset_n = 1'b0;
            #3 reset_n = 1'b1;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
